// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: FETCH/DECODE/execute/writeback FSM.
// Opcode is captured at DECODE so later states ignore changes on OP.
module multicycle_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] OP,
    input  logic       MEM_READY,
    output logic       PCWRITE,
    output logic       BRANCH,
    output logic       BNE,
    output logic       IORD,
    output logic       MEMREAD,
    output logic       MEMWRITE,
    output logic       IRWRITE,
    output logic       REGDST,
    output logic       M2REG,
    output logic       WREG,
    output logic       ALUSRCA,
    output logic       DONE,
    output logic       ILLEGAL,
    output logic [1:0] ALUSRCB,
    output logic [1:0] PCSRC,
    output logic [1:0] ALUOP,
    output logic [3:0] STATE
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REXEC  = 4'd6,
        RWB    = 4'd7,
        IEXEC  = 4'd8,
        IWB    = 4'd9,
        BR     = 4'd10,
        JMP    = 4'd11,
        ILL    = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     state;
    state_t     state_next;
    logic [5:0] opq;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
            opq   <= 6'b000000;
        end else begin
            state <= state_next;
            if (state == DECODE)
                opq <= OP;
        end
    end

    assign STATE = RST ? FETCH : state;

    always_comb begin
        state_next = state;
        PCWRITE    = 1'b0;
        BRANCH     = 1'b0;
        BNE        = 1'b0;
        IORD       = 1'b0;
        MEMREAD    = 1'b0;
        MEMWRITE   = 1'b0;
        IRWRITE    = 1'b0;
        REGDST     = 1'b0;
        M2REG      = 1'b0;
        WREG       = 1'b0;
        ALUSRCA    = 1'b0;
        DONE       = 1'b0;
        ILLEGAL    = 1'b0;
        ALUSRCB    = 2'b00;
        PCSRC      = 2'b00;
        ALUOP      = 2'b00;

        if (RST) begin
            // Present the idle FETCH view, but never write PC/IR in reset.
            state_next = FETCH;
            MEMREAD    = 1'b1;
            ALUSRCB    = 2'b01;
        end else begin
            case (state)
                FETCH: begin
                    MEMREAD = 1'b1;
                    ALUSRCB = 2'b01;
                    IRWRITE = MEM_READY;
                    PCWRITE = MEM_READY;
                    if (MEM_READY)
                        state_next = DECODE;
                end
                DECODE: begin
                    ALUSRCB = 2'b11;
                    case (OP)
                        OP_R:    state_next = REXEC;
                        OP_ADDI,
                        OP_ORI,
                        OP_SLTI: state_next = IEXEC;
                        OP_LW,
                        OP_SW:   state_next = MEMADR;
                        OP_BEQ,
                        OP_BNE:  state_next = BR;
                        OP_J:    state_next = JMP;
                        default: state_next = ILL;
                    endcase
                end
                MEMADR: begin
                    ALUSRCA    = 1'b1;
                    ALUSRCB    = 2'b10;
                    state_next = (opq == OP_LW) ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    MEMREAD = 1'b1;
                    IORD    = 1'b1;
                    if (MEM_READY)
                        state_next = MEMWB;
                end
                MEMWB: begin
                    WREG       = 1'b1;
                    M2REG      = 1'b1;
                    DONE       = 1'b1;
                    state_next = FETCH;
                end
                MEMWR: begin
                    MEMWRITE = 1'b1;
                    IORD     = 1'b1;
                    DONE     = MEM_READY;
                    if (MEM_READY)
                        state_next = FETCH;
                end
                REXEC: begin
                    ALUSRCA    = 1'b1;
                    ALUOP      = 2'b10;
                    state_next = RWB;
                end
                RWB: begin
                    WREG       = 1'b1;
                    REGDST     = 1'b1;
                    DONE       = 1'b1;
                    state_next = FETCH;
                end
                IEXEC: begin
                    ALUSRCA = 1'b1;
                    ALUSRCB = 2'b10;
                    case (opq)
                        OP_ORI:  ALUOP = 2'b11;
                        OP_SLTI: ALUOP = 2'b01;
                        default: ALUOP = 2'b00;
                    endcase
                    state_next = IWB;
                end
                IWB: begin
                    WREG       = 1'b1;
                    DONE       = 1'b1;
                    state_next = FETCH;
                end
                BR: begin
                    ALUSRCA    = 1'b1;
                    ALUOP      = 2'b01;
                    PCSRC      = 2'b01;
                    BRANCH     = 1'b1;
                    BNE        = (opq == OP_BNE);
                    DONE       = 1'b1;
                    state_next = FETCH;
                end
                JMP: begin
                    PCWRITE    = 1'b1;
                    PCSRC      = 2'b10;
                    DONE       = 1'b1;
                    state_next = FETCH;
                end
                ILL: begin
                    ILLEGAL    = 1'b1;
                    state_next = ILL;
                end
                default: state_next = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class,
// memory stalls, opcode capture, the illegal trap and reset behaviour.
module tb_multicycle_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] OP;
    logic       MEM_READY;
    logic       PCWRITE, BRANCH, BNE, IORD, MEMREAD, MEMWRITE, IRWRITE;
    logic       REGDST, M2REG, WREG, ALUSRCA, DONE, ILLEGAL;
    logic [1:0] ALUSRCB, PCSRC, ALUOP;
    logic [3:0] STATE;

    int n_run  = 0;
    int n_fail = 0;

    multicycle_ctrl dut (
        .CLK(CLK), .RST(RST), .OP(OP), .MEM_READY(MEM_READY),
        .PCWRITE(PCWRITE), .BRANCH(BRANCH), .BNE(BNE), .IORD(IORD),
        .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE), .IRWRITE(IRWRITE),
        .REGDST(REGDST), .M2REG(M2REG), .WREG(WREG), .ALUSRCA(ALUSRCA),
        .DONE(DONE), .ILLEGAL(ILLEGAL), .ALUSRCB(ALUSRCB), .PCSRC(PCSRC),
        .ALUOP(ALUOP), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST       = 1'b1;
        OP        = 6'b000000;
        MEM_READY = 1'b0;
        tick();
        tick();
        chk("rst_state", STATE, 0);
        chk("rst_memread", MEMREAD, 1);
        chk("rst_alusrcb", ALUSRCB, 1);
        chk("rst_irwrite", IRWRITE, 0);
        MEM_READY = 1'b1;
        #1;
        chk("rst_pcwrite_forced", PCWRITE, 0);
        chk("rst_irwrite_forced", IRWRITE, 0);

        // lw, no wait states
        RST = 1'b0;
        OP  = 6'b100011;
        #1;
        chk("lw_fetch_state", STATE, 0);
        chk("lw_fetch_irwrite", IRWRITE, 1);
        chk("lw_fetch_pcwrite", PCWRITE, 1);
        tick();
        chk("lw_decode_state", STATE, 1);
        chk("lw_decode_alusrcb", ALUSRCB, 3);
        tick();
        chk("lw_memadr_state", STATE, 2);
        chk("lw_memadr_srca", ALUSRCA, 1);
        chk("lw_memadr_srcb", ALUSRCB, 2);
        tick();
        chk("lw_memrd_state", STATE, 3);
        chk("lw_memrd_iord", IORD, 1);
        chk("lw_memrd_memread", MEMREAD, 1);
        tick();
        chk("lw_memwb_state", STATE, 4);
        chk("lw_memwb_wreg", WREG, 1);
        chk("lw_memwb_m2reg", M2REG, 1);
        chk("lw_memwb_done", DONE, 1);
        tick();
        chk("lw_back_fetch", STATE, 0);

        // sw with three stall cycles in MEMWR
        OP = 6'b101011;
        tick();
        tick();
        chk("sw_memadr_state", STATE, 2);
        MEM_READY = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("sw_wait_state", STATE, 5);
            chk("sw_wait_memwrite", MEMWRITE, 1);
            chk("sw_wait_done", DONE, 0);
            tick();
        end
        MEM_READY = 1'b1;
        #1;
        chk("sw_last_state", STATE, 5);
        chk("sw_last_memwrite", MEMWRITE, 1);
        chk("sw_last_done", DONE, 1);
        tick();
        chk("sw_back_fetch", STATE, 0);

        // bne then beq
        OP = 6'b000101;
        tick();
        tick();
        chk("bne_state", STATE, 10);
        chk("bne_pcsrc", PCSRC, 1);
        chk("bne_branch", BRANCH, 1);
        chk("bne_bne", BNE, 1);
        chk("bne_done", DONE, 1);
        tick();
        OP = 6'b000100;
        tick();
        tick();
        chk("beq_state", STATE, 10);
        chk("beq_branch", BRANCH, 1);
        chk("beq_bne", BNE, 0);
        tick();

        // ori with OP changed during IEXEC
        OP = 6'b001101;
        tick();
        tick();
        OP = 6'b001010;
        #1;
        chk("ori_iexec_state", STATE, 8);
        chk("ori_aluop", ALUOP, 3);
        tick();
        chk("ori_iwb_state", STATE, 9);
        chk("ori_iwb_wreg", WREG, 1);
        chk("ori_iwb_regdst", REGDST, 0);
        chk("ori_iwb_done", DONE, 1);
        tick();

        // R-type
        OP = 6'b000000;
        tick();
        tick();
        chk("r_rexec_state", STATE, 6);
        chk("r_rexec_aluop", ALUOP, 2);
        tick();
        chk("r_rwb_regdst", REGDST, 1);
        chk("r_rwb_wreg", WREG, 1);
        tick();

        // jump
        OP = 6'b000010;
        tick();
        tick();
        chk("j_state", STATE, 11);
        chk("j_pcwrite", PCWRITE, 1);
        chk("j_pcsrc", PCSRC, 2);
        chk("j_done", DONE, 1);
        tick();
        chk("j_back_fetch", STATE, 0);

        // illegal opcode trap
        OP = 6'b111111;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("ill_state", STATE, 12);
            chk("ill_flag", ILLEGAL, 1);
            chk("ill_done", DONE, 0);
            tick();
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        chk("ill_rst_state", STATE, 0);
        chk("ill_rst_flag", ILLEGAL, 0);

        // reset while waiting in MEMRD
        OP = 6'b100011;
        MEM_READY = 1'b1;
        tick();
        tick();
        MEM_READY = 1'b0;
        tick();
        chk("mw_memrd_state", STATE, 3);
        chk("mw_memrd_iord", IORD, 1);
        RST = 1'b1;
        #1;
        chk("mw_rst_iord", IORD, 0);
        chk("mw_rst_wreg", WREG, 0);
        tick();
        RST = 1'b0;
        #1;
        chk("mw_after_state", STATE, 0);
        chk("mw_after_iord", IORD, 0);
        chk("mw_after_wreg", WREG, 0);
        tick();
        chk("mw_hold_state", STATE, 0);
        chk("mw_hold_wreg", WREG, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
